// File: rtl/ghost_nav.sv
// ============================================================================
// ghost_nav -- wall-aware, target-seeking movement controller for one ghost.
//
// Each accepted step pulse runs four EVAL cycles (one per candidate
// neighbour, in the order up, left, down, right), then one MOVE cycle that
// commits the chosen tile. The selection rules are:
//   * A candidate is open when it lies inside the grid and its wall bit is 0.
//   * Among the open candidates that are not the reverse of the current
//     heading, the lowest squared distance to the target wins. On a tie the
//     earlier candidate in the order wins.
//   * The reverse direction is taken only when it is the sole open
//     direction, or when a forced reversal (caused by a mode change) is
//     pending and the reverse tile is open.
//
// Optional feature macro: GHOST_FRIGHT_EN
//   Defined   : an 8-bit Galois LFSR (taps 8,6,5,4) runs every clock. In
//               frightened mode the first open non-reverse candidate at or
//               after index LFSR[1:0] (cyclic up, left, down, right) wins.
//   Undefined : no LFSR. Frightened mode behaves exactly like scatter.
//
// Ports
//   i_clk             system clock
//   i_reset           asynchronous, active-high reset
//   i_step            one-cycle move request (ignored while busy)
//   i_mode            0=chase, 1=scatter, 2=frightened, 3=hold
//   i_target_col/row  chase target tile, sampled at step acceptance
//   i_tilemap_walls   bit[row*COLS+col]=1 marks a wall; read during EVAL
//   o_x / o_y         pixel position (tile index * TILE_SIZE), registered
//   o_ghost_direction current heading (DIR_UP/DIR_LEFT/DIR_DOWN/DIR_RIGHT)
//   o_busy            high from step acceptance until the move completes
//   o_done            one-cycle pulse when the new position is valid
// ============================================================================

// Direction codes. The numeric values equal the candidate evaluation order,
// and the opposite of any direction is that code with bit 1 flipped.
`ifndef DIR_UP
`define DIR_UP    2'd0
`endif
`ifndef DIR_LEFT
`define DIR_LEFT  2'd1
`endif
`ifndef DIR_DOWN
`define DIR_DOWN  2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

module ghost_nav #(
  parameter int         TILE_SIZE   = 20,
  parameter int         COLS        = 32,
  parameter int         ROWS        = 24,
  parameter int         START_COL   = 30,
  parameter int         START_ROW   = 16,
  parameter logic [1:0] START_DIR   = `DIR_DOWN,
  parameter int         SCATTER_COL = 31,
  parameter int         SCATTER_ROW = 23,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_step,
  input  logic [1:0]                          i_mode,
  input  logic [$clog2(COLS)-1:0]             i_target_col,
  input  logic [$clog2(ROWS)-1:0]             i_target_row,
  input  logic [ROWS*COLS-1:0]                i_tilemap_walls,
  output logic [$clog2(COLS*TILE_SIZE)-1:0]   o_x,
  output logic [$clog2(ROWS*TILE_SIZE)-1:0]   o_y,
  output logic [1:0]                          o_ghost_direction,
  output logic                                o_busy,
  output logic                                o_done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int XW = $clog2(COLS*TILE_SIZE);
  localparam int YW = $clog2(ROWS*TILE_SIZE);
  localparam int IW = $clog2(ROWS*COLS);
  localparam int MW = (CW > RW) ? CW : RW;
  localparam int SW = 2*MW + 1;

  localparam logic [1:0] MODE_CHASE   = 2'd0;
  localparam logic [1:0] MODE_SCATTER = 2'd1;
  localparam logic [1:0] MODE_HOLD    = 2'd3;

  // An all-zero seed would lock the LFSR; reject it at elaboration.
  if (LFSR_SEED == 8'h00) begin : g_seed_check
    $error("ghost_nav: LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_MOVE
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [1:0]        r_dir;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_idx;         // candidate under evaluation
  logic [CW-1:0]     r_tcol;        // latched target
  logic [RW-1:0]     r_trow;
  logic [3:0]        r_open;        // open flag per candidate
  logic              r_best_valid;  // a non-reverse open candidate was seen
  logic [1:0]        r_best_dir;
  logic [SW-1:0]     r_best_score;
  logic              r_force;       // forced reversal pending
  logic [1:0]        r_prev_mode;   // mode of the previous accepted step

`ifdef GHOST_FRIGHT_EN
  logic [7:0]        r_lfsr;
  logic [1:0]        r_rand;        // LFSR[1:0] latched at acceptance
  logic              r_fright;      // latched mode is frightened
`endif

  // --------------------------------------------------------------------------
  // Effective mode: without the frightened feature, mode 2 is scatter in
  // every respect, including how mode changes trigger a forced reversal.
  // --------------------------------------------------------------------------
  logic [1:0] w_mode_eff;
`ifdef GHOST_FRIGHT_EN
  assign w_mode_eff = i_mode;
`else
  assign w_mode_eff = (i_mode == 2'd2) ? MODE_SCATTER : i_mode;
`endif

  // --------------------------------------------------------------------------
  // Candidate neighbour for the current EVAL index. Off-grid neighbours are
  // treated as walls, so the coordinate is only stepped when it stays inside.
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_ncol;
  logic [RW-1:0] w_nrow;
  logic          w_in_grid;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_ncol    = r_col;
    w_nrow    = r_row;
    w_in_grid = 1'b0;
    case (r_idx)
      `DIR_UP: begin
        w_in_grid = (r_row != '0);
        if (w_in_grid) w_nrow = r_row - 1'b1;
      end
      `DIR_LEFT: begin
        w_in_grid = (r_col != '0);
        if (w_in_grid) w_ncol = r_col - 1'b1;
      end
      `DIR_DOWN: begin
        w_in_grid = (r_row != RW'(ROWS-1));
        if (w_in_grid) w_nrow = r_row + 1'b1;
      end
      default: begin
        w_in_grid = (r_col != CW'(COLS-1));
        if (w_in_grid) w_ncol = r_col + 1'b1;
      end
    endcase
  end

  logic [IW-1:0] w_wall_idx;
  logic          w_open;
  logic [CW-1:0] w_dx;
  logic [RW-1:0] w_dy;
  logic [SW-1:0] w_score;

  assign w_wall_idx = IW'(w_nrow) * IW'(COLS) + IW'(w_ncol);
  assign w_open     = w_in_grid & ~i_tilemap_walls[w_wall_idx];
  assign w_dx       = (w_ncol >= r_tcol) ? (w_ncol - r_tcol) : (r_tcol - w_ncol);
  assign w_dy       = (w_nrow >= r_trow) ? (w_nrow - r_trow) : (r_trow - w_nrow);
  assign w_score    = SW'(w_dx) * SW'(w_dx) + SW'(w_dy) * SW'(w_dy);

  // --------------------------------------------------------------------------
  // Move decision, consumed in the MOVE cycle.
  // --------------------------------------------------------------------------
  logic [1:0] w_rev;
  logic [3:0] w_nonrev;
  logic [1:0] w_pick_dir;

  assign w_rev    = r_dir ^ 2'd2;
  assign w_nonrev = r_open & ~(4'b0001 << w_rev);

`ifdef GHOST_FRIGHT_EN
  logic [1:0] w_fr_dir;
  logic [1:0] w_cand;

  // Walk the cyclic order downwards so the lowest offset from r_rand that is
  // open wins the final assignment.
  always_comb begin
    w_fr_dir = r_best_dir;
    w_cand   = r_rand;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_rand + 2'(k);
      if (w_nonrev[w_cand]) w_fr_dir = w_cand;
    end
  end

  assign w_pick_dir = r_fright ? w_fr_dir : r_best_dir;
`else
  assign w_pick_dir = r_best_dir;
`endif

  logic       w_sel_valid;
  logic [1:0] w_sel_dir;
  logic       w_consume;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_dir   = r_dir;
    w_consume   = 1'b0;
    if (r_force && r_open[w_rev]) begin
      w_sel_valid = 1'b1;
      w_sel_dir   = w_rev;
      w_consume   = 1'b1;
    end else if (|w_nonrev) begin
      w_sel_valid = 1'b1;
      w_sel_dir   = w_pick_dir;
    end else if (r_open[w_rev]) begin
      w_sel_valid = 1'b1;
      w_sel_dir   = w_rev;
    end
  end

  // Destination tile; a selected direction is always open, hence in-grid.
  logic [CW-1:0] w_mcol;
  logic [RW-1:0] w_mrow;

  always_comb begin
    w_mcol = r_col;
    w_mrow = r_row;
    if (w_sel_valid) begin
      case (w_sel_dir)
        `DIR_UP:   w_mrow = r_row - 1'b1;
        `DIR_LEFT: w_mcol = r_col - 1'b1;
        `DIR_DOWN: w_mrow = r_row + 1'b1;
        default:   w_mcol = r_col + 1'b1;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Free-running LFSR for frightened mode.
  // --------------------------------------------------------------------------
`ifdef GHOST_FRIGHT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_col        <= CW'(START_COL);
      r_row        <= RW'(START_ROW);
      r_dir        <= START_DIR;
      r_x          <= XW'(START_COL * TILE_SIZE);
      r_y          <= YW'(START_ROW * TILE_SIZE);
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_idx        <= 2'd0;
      r_tcol       <= '0;
      r_trow       <= '0;
      r_open       <= 4'b0000;
      r_best_valid <= 1'b0;
      r_best_dir   <= 2'd0;
      r_best_score <= '0;
      r_force      <= 1'b0;
      r_prev_mode  <= MODE_CHASE;
`ifdef GHOST_FRIGHT_EN
      r_rand       <= 2'd0;
      r_fright     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_step && (i_mode != MODE_HOLD)) begin
            if (w_mode_eff == MODE_CHASE) begin
              r_tcol <= i_target_col;
              r_trow <= i_target_row;
            end else begin
              r_tcol <= CW'(SCATTER_COL);
              r_trow <= RW'(SCATTER_ROW);
            end
            // A pending reversal survives until a move actually uses it.
            if (w_mode_eff != r_prev_mode) r_force <= 1'b1;
            r_prev_mode  <= w_mode_eff;
`ifdef GHOST_FRIGHT_EN
            r_rand       <= r_lfsr[1:0];
            r_fright     <= (w_mode_eff == 2'd2);
`endif
            r_idx        <= 2'd0;
            r_open       <= 4'b0000;
            r_best_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_EVAL;
          end
        end

        S_EVAL: begin
          r_open[r_idx] <= w_open;
          // Strict less-than keeps the earlier candidate on a tie.
          if (w_open && (r_idx != w_rev) &&
              (!r_best_valid || (w_score < r_best_score))) begin
            r_best_valid <= 1'b1;
            r_best_dir   <= r_idx;
            r_best_score <= w_score;
          end
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= S_MOVE;
        end

        S_MOVE: begin
          if (w_sel_valid) begin
            r_col <= w_mcol;
            r_row <= w_mrow;
            r_dir <= w_sel_dir;
            r_x   <= XW'(w_mcol) * XW'(TILE_SIZE);
            r_y   <= YW'(w_mrow) * YW'(TILE_SIZE);
          end
          if (w_consume) r_force <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_x               = r_x;
  assign o_y               = r_y;
  assign o_ghost_direction = r_dir;
  assign o_busy            = r_busy;
  assign o_done            = r_done;

endmodule

// File: tb/tb_ghost_nav.sv
// ============================================================================
// tb_ghost_nav -- scoreboard bench for ghost_nav.
//
// The stimulus process drives step requests and, for each accepted request,
// pushes the expected tile/heading computed by a grid-level reference model.
// An independent monitor pops and compares whenever o_done pulses.
// ============================================================================
`timescale 1ns/1ps

`ifndef DIR_UP
`define DIR_UP    2'd0
`endif
`ifndef DIR_LEFT
`define DIR_LEFT  2'd1
`endif
`ifndef DIR_DOWN
`define DIR_DOWN  2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

module tb_ghost_nav;

  localparam int COLS  = 32;
  localparam int ROWS  = 24;
  localparam int TILE  = 20;
  localparam int SC_C  = 31;
  localparam int SC_R  = 23;
  localparam int ST_C  = 30;
  localparam int ST_R  = 16;

  // Reference model tables, indexed by evaluation order up, left, down, right.
  localparam int DC[4]       = '{0, -1, 0, 1};
  localparam int DR[4]       = '{-1, 0, 1, 0};
  localparam int OPP[4]      = '{2, 3, 0, 1};
  localparam int DIR_CODE[4] = '{`DIR_UP, `DIR_LEFT, `DIR_DOWN, `DIR_RIGHT};

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 step;
  logic [1:0]           mode;
  logic [4:0]           tcol;
  logic [4:0]           trow;
  logic [ROWS*COLS-1:0] walls;
  logic [9:0]           x;
  logic [8:0]           y;
  logic [1:0]           dir;
  logic                 busy;
  logic                 done;

  ghost_nav dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_step            (step),
    .i_mode            (mode),
    .i_target_col      (tcol),
    .i_target_row      (trow),
    .i_tilemap_walls   (walls),
    .o_x               (x),
    .o_y               (y),
    .o_ghost_direction (dir),
    .o_busy            (busy),
    .o_done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int col;
    int row;
    int dir;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model state (tile coordinates, heading as order index).
  // --------------------------------------------------------------------------
  int       m_col, m_row, m_dir, m_force, m_prev;
  bit [7:0] m_lfsr;

  // Frightened-mode randomness source: x^8+x^6+x^5+x^4+1, shifted right.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr = 8'hA5;
    else begin
      bit lsb;
      lsb    = m_lfsr[0];
      m_lfsr = m_lfsr >> 1;
      if (lsb) m_lfsr = m_lfsr ^ 8'hB8;
    end
  end

  function automatic bit tile_open(input int c, input int r);
    if (c < 0 || c >= COLS || r < 0 || r >= ROWS) return 1'b0;
    return !walls[r*COLS + c];
  endfunction

  task automatic model_reset();
    m_col = ST_C; m_row = ST_R; m_dir = 2; m_force = 0; m_prev = 0;
    sb_q.delete();
  endtask

  task automatic model_step(input int md, input int tc_in, input int tr_in);
    int   eff, tc, tr, rev, sel, best, d;
    bit   open[4];
    int   score[4];
    exp_t e;
    eff = md;
`ifndef GHOST_FRIGHT_EN
    if (eff == 2) eff = 1;
`endif
    if (eff != m_prev) m_force = 1;
    m_prev = eff;
    if (eff == 0) begin tc = tc_in; tr = tr_in; end
    else begin tc = SC_C; tr = SC_R; end
    for (int i = 0; i < 4; i++) begin
      open[i]  = tile_open(m_col + DC[i], m_row + DR[i]);
      score[i] = (m_col + DC[i] - tc) ** 2 + (m_row + DR[i] - tr) ** 2;
    end
    rev  = OPP[m_dir];
    sel  = -1;
    best = 0;
    if (m_force != 0 && open[rev]) begin
      sel = rev;
      m_force = 0;
    end else begin
      if (eff == 2) begin
        for (int k = 0; k < 4; k++) begin
          d = (int'(m_lfsr[1:0]) + k) % 4;
          if (sel < 0 && d != rev && open[d]) sel = d;
        end
      end else begin
        for (int i = 0; i < 4; i++)
          if (i != rev && open[i] && (sel < 0 || score[i] < best)) begin
            sel  = i;
            best = score[i];
          end
      end
      if (sel < 0 && open[rev]) sel = rev;
    end
    if (sel >= 0) begin
      m_col = m_col + DC[sel];
      m_row = m_row + DR[sel];
      m_dir = sel;
    end
    e.col = m_col; e.row = m_row; e.dir = DIR_CODE[m_dir];
    sb_q.push_back(e);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: compares every done pulse against the oldest expectation.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) check("unexpected_done", int'(done), 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        check("x",   int'(x),   e.col * TILE);
        check("y",   int'(y),   e.row * TILE);
        check("dir", int'(dir), e.dir);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic do_step(input int md, input int tc, input int tr, input bit noise);
    int k;
    @(negedge clk);
    step = 1'b1; mode = 2'(md); tcol = 5'(tc); trow = 5'(tr);
    if (md != 3) model_step(md, tc, tr);
    @(negedge clk);
    step = 1'b0;
    if (md == 3) begin
      for (int i = 0; i < 4; i++) begin
        check("hold_busy", int'(busy), 0);
        @(negedge clk);
      end
      return;
    end
    k = 1;
    check("busy_start", int'(busy), 1);
    while (!done && k < 20) begin
      if (noise && k == 2) begin
        step = 1'b1;
        mode = 2'((md + 1) % 3);
        tcol = 5'($urandom_range(0, COLS-1));
        trow = 5'($urandom_range(0, ROWS-1));
      end else step = 1'b0;
      @(negedge clk);
      k++;
    end
    step = 1'b0;
    check("latency", k, 6);
    check("busy_end", int'(busy), 0);
  endtask

  task automatic set_wall(input int d, input bit v);
    int c, r;
    c = m_col + DC[d];
    r = m_row + DR[d];
    if (c >= 0 && c < COLS && r >= 0 && r < ROWS) walls[r*COLS + c] = v;
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_x"},    int'(x),    ST_C * TILE);
    check({tag, "_y"},    int'(y),    ST_R * TILE);
    check({tag, "_dir"},  int'(dir),  int'(`DIR_DOWN));
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    reset = 1'b1; step = 1'b0; mode = 2'd0; tcol = '0; trow = '0; walls = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // Open area, chase a tile straight above: up is the reverse heading.
    do_step(0, m_col, clampi(m_row - 5, ROWS-1), 1'b0);
    // Open area again, now chase above while heading sideways.
    do_step(0, m_col, clampi(m_row - 5, ROWS-1), 1'b0);

    // Corridor: block both sides, target behind -> must keep going forward.
    walls = '0;
    set_wall((m_dir + 1) % 4, 1'b1);
    set_wall((m_dir + 3) % 4, 1'b1);
    do_step(0, clampi(m_col - 3*DC[m_dir], COLS-1),
               clampi(m_row - 3*DR[m_dir], ROWS-1), 1'b0);

    // Dead end: only the reverse tile is open.
    walls = '0;
    for (int d = 0; d < 4; d++) set_wall(d, 1'b1);
    set_wall(OPP[m_dir], 1'b0);
    do_step(0, $urandom_range(0, COLS-1), $urandom_range(0, ROWS-1), 1'b0);

    // Fully enclosed: no move, done still pulses.
    walls = '0;
    for (int d = 0; d < 4; d++) set_wall(d, 1'b1);
    do_step(0, 0, 0, 1'b0);

    // Chase then scatter: the mode change forces one reversal.
    walls = '0;
    do_step(0, 0, 0, 1'b0);
    do_step(1, 0, 0, 1'b0);
    do_step(1, 0, 0, 1'b0);

    // Step pulses while busy, then hold-mode requests.
    do_step(0, 3, 3, 1'b1);
    do_step(3, 3, 3, 1'b0);
    do_step(3, 10, 10, 1'b0);

    // Reset asserted during EVAL aborts the move.
    @(negedge clk);
    step = 1'b1; mode = 2'd1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset_state("abort");
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", int'(done), 0);

    // Frightened (or scatter-equivalent) walk on an open map.
    walls = '0;
    for (int i = 0; i < 16; i++) do_step(2, 0, 0, 1'b0);

    // Randomised walk: sparse random walls, random modes and targets.
    for (int i = 0; i < 40; i++) begin
      for (int b = 0; b < ROWS*COLS; b++) walls[b] = ($urandom_range(0, 7) == 0);
      do_step($urandom_range(0, 3), $urandom_range(0, COLS-1),
              $urandom_range(0, ROWS-1), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/ghost_nav.md
# ghost_nav

Parametrised ghost movement controller that replaces fixed per-ghost waypoint tables with wall-aware, target-seeking navigation. On each `step` pulse it evaluates the four neighbouring tiles against `tilemap_walls` and moves one tile toward a target chosen by the current mode: chase, scatter or frightened. Each ghost is one instance, driven by the game tick and feeding the sprite renderer and collision logic.

## Interface
- `TILE_SIZE`, 20, pixels per tile; output pixel = tile index × TILE_SIZE
- `COLS`, 32, tile columns; `ROWS`, 24, tile rows
- `START_COL`, 30, `START_ROW`, 16, reset tile
- `START_DIR`, `dir_down`, reset heading
- `SCATTER_COL`, 31, `SCATTER_ROW`, 23, scatter-mode target tile
- `LFSR_SEED`, 8'hA5, frightened-mode LFSR seed (must be nonzero)
- `clk` in 1 system clock
- `reset` in 1 asynchronous, active-high; all state to reset values immediately
- `step` in 1 one-cycle move request
- `mode` in 2 0=chase, 1=scatter, 2=frightened, 3=hold
- `target_col` in $clog2(COLS) chase target column
- `target_row` in $clog2(ROWS) chase target row
- `tilemap_walls` in ROWS*COLS bit[row*COLS+col]=1 means wall
- `x` out $clog2(COLS*TILE_SIZE) pixel x of ghost
- `y` out $clog2(ROWS*TILE_SIZE) pixel y of ghost
- `ghost_direction` out 2 current heading, `dir_up`/`dir_down`/`dir_left`/`dir_right` from define.v
- `busy` out 1 high from step acceptance until move completes
- `done` out 1 one-cycle pulse when the new position is valid

## Operation
- Internal tile counters `col`, `row`; `x`=col*TILE_SIZE, `y`=row*TILE_SIZE, registered.
- FSM: IDLE → EVAL → MOVE → IDLE.
  - IDLE: `step` with `mode`≠3 → latch mode/target, EVAL, `busy`=1. Mode 3 or no step: remain.
  - EVAL: 4 cycles, candidate order up, left, down, right. Per candidate: open = neighbour in grid AND wall bit 0. Score = dx²+dy² (unsigned, width 2·max(clog2 COLS, clog2 ROWS)+1) to target.
  - Target: chase = target_col/row; scatter = SCATTER_COL/ROW; frightened = random (see Configuration).
  - Selection: lowest score among open non-reverse candidates; ties to earlier in order.
  - MOVE: update col/row and `ghost_direction`; assert `done`; `busy` low; return to IDLE.
- Reverse (opposite of current heading) is chosen only if it is the sole open direction, or if a forced reversal is pending and reverse is open.
- Forced reversal: set when latched mode differs from the previous accepted step's mode; cleared on the move that consumes it.
- All four blocked: position unchanged, heading unchanged, `done` still pulses.
- Grid edge: off-grid neighbours are walls; no wrap tunnel.

## Timing
- Reset values: col=START_COL, row=START_ROW, heading=START_DIR, busy=0, done=0, FSM IDLE, LFSR=LFSR_SEED, reversal flag 0, previous mode = chase.
- Step accepted in cycle N → `done` and new `x`/`y`/`ghost_direction` visible cycle N+6 (EVAL N+1..N+4, MOVE N+5, registered outputs N+6).
- `step` while `busy`: ignored, not queued.
- `mode`/`target` sampled only at acceptance; changes mid-EVAL have no effect.
- `tilemap_walls` sampled combinationally during each EVAL cycle; must be stable while `busy`.
- `reset` mid-operation aborts EVAL/MOVE; no `done` pulse.

## Configuration
- `GHOST_FRIGHT_EN` defined: 8-bit Galois LFSR (taps 8,6,5,4) advances every clock; in frightened mode, the first open non-reverse candidate at or after index LFSR[1:0] (cyclic order up, left, down, right) is chosen.
- Undefined: no LFSR; mode 2 behaves exactly as scatter, including forced-reversal rules.

## Test plan
- Open 3×3 area, ghost at (5,5) heading right, chase target (5,1), step → after 6 cycles heading `dir_up`, row=4, y=80, done pulse.
- Corridor: walls above/below, heading right, target directly left at (2,5) → continues right (no reverse), col+1.
- Dead end: only reverse open → reverses, moves one tile back; all four blocked → position/heading unchanged, done still pulses.
- Mode chase→scatter with reverse open → next step reverses; following step resumes normal selection.
- Step pulses during busy and mode=3 → no moves, busy stays low in hold; reset asserted mid-EVAL → x=START_COL*20=600, y=320, heading `dir_down`, no done.
- With `GHOST_FRIGHT_EN`, seed 8'hA5, mode 2, all directions open → chosen direction matches LFSR[1:0] reference model over 16 steps; without it, same stimulus matches scatter results.
